// File: rtl/load_store_unit.sv
// Load/store unit: checks RISC-V access alignment, drives a registered
// req/gnt/rvalid data-memory port and returns extended load data with a watchdog.
module load_store_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  misaligned,
  output logic                  bus_timeout,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] dmem_rdata,
  output logic [2:0]            dbg_state
);

  // Handshake: a request transfers on the rising edge where req_valid && req_ready
  // and at least one of mem_read/mem_write is set; dmem_req stays high until dmem_gnt.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_RESP = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [1:0]              addr_lo_q, addr_lo_d;
  logic [2:0]              funct3_q, funct3_d;
  logic                    timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    dmem_req_q, dmem_req_d;
  logic                    dmem_we_q, dmem_we_d;
  logic [ADDR_WIDTH-1:0]   dmem_addr_q, dmem_addr_d;
  logic [3:0]              dmem_be_q, dmem_be_d;
  logic [DATA_WIDTH-1:0]   dmem_wdata_q, dmem_wdata_d;

  logic                    accept;
  logic                    illegal;
  logic [3:0]              be_calc;
  logic [DATA_WIDTH-1:0]   wdata_calc;
  logic [7:0]              byte_sel;
  logic [15:0]             half_sel;
  logic [DATA_WIDTH-1:0]   load_ext;

  assign accept = req_valid && (state_q == S_IDLE) && (mem_read || mem_write);

  // funct3[1:0] encodes the size for both signed and unsigned forms.
  always_comb begin
    illegal = 1'b0;
    if (mem_read && mem_write) begin
      illegal = 1'b1;
    end else if (mem_read && ((funct3 == 3'd3) || (funct3[2:1] == 2'b11))) begin
      illegal = 1'b1;
    end else if (mem_write && (funct3 > 3'd2)) begin
      illegal = 1'b1;
    end else if ((funct3[1:0] == 2'b01) && addr[0]) begin
      illegal = 1'b1;
    end else if ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)) begin
      illegal = 1'b1;
    end
  end

  always_comb begin
    be_calc    = 4'b1111;
    wdata_calc = wdata;
    case (funct3[1:0])
      2'b00: begin
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      default: begin
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
    endcase
  end

  always_comb begin
    byte_sel = dmem_rdata[7:0];
    case (addr_lo_q)
      2'd0:    byte_sel = dmem_rdata[7:0];
      2'd1:    byte_sel = dmem_rdata[15:8];
      2'd2:    byte_sel = dmem_rdata[23:16];
      default: byte_sel = dmem_rdata[31:24];
    endcase
    half_sel = addr_lo_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (funct3_q)
      3'd0:    load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'd4:    load_ext = {24'd0, byte_sel};
      3'd1:    load_ext = {{16{half_sel[15]}}, half_sel};
      3'd5:    load_ext = {16'd0, half_sel};
      default: load_ext = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_lo_d    = addr_lo_q;
    funct3_d     = funct3_q;
    timeout_d    = timeout_q;
    rdata_d      = rdata_q;
    dmem_req_d   = dmem_req_q;
    dmem_we_d    = dmem_we_q;
    dmem_addr_d  = dmem_addr_q;
    dmem_be_d    = dmem_be_q;
    dmem_wdata_d = dmem_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d     = '0;
          addr_lo_d = addr[1:0];
          funct3_d  = funct3;
          if (illegal) begin
            state_d   = S_ERR;
            timeout_d = 1'b0;
            rdata_d   = '0;
          end else begin
            state_d      = S_REQ;
            dmem_req_d   = 1'b1;
            dmem_we_d    = mem_write;
            dmem_addr_d  = {addr[ADDR_WIDTH-1:2], 2'b00};
            dmem_be_d    = be_calc;
            dmem_wdata_d = wdata_calc;
          end
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_gnt) begin
          dmem_req_d = 1'b0;
          state_d    = dmem_we_q ? S_RESP : S_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          dmem_req_d = 1'b0;
          state_d    = S_ERR;
          timeout_d  = 1'b1;
          rdata_d    = '0;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (dmem_rvalid) begin
          rdata_d = load_ext;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_ERR;
          timeout_d = 1'b1;
          rdata_d   = '0;
        end
      end
      S_RESP:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_lo_q    <= 2'b00;
      funct3_q     <= 3'd0;
      timeout_q    <= 1'b0;
      rdata_q      <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= 4'b0000;
      dmem_wdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_lo_q    <= addr_lo_d;
      funct3_q     <= funct3_d;
      timeout_q    <= timeout_d;
      rdata_q      <= rdata_d;
      dmem_req_q   <= dmem_req_d;
      dmem_we_q    <= dmem_we_d;
      dmem_addr_q  <= dmem_addr_d;
      dmem_be_q    <= dmem_be_d;
      dmem_wdata_q <= dmem_wdata_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign resp_valid  = (state_q == S_RESP) || (state_q == S_ERR);
  assign misaligned  = (state_q == S_ERR) && !timeout_q;
  assign bus_timeout = (state_q == S_ERR) && timeout_q;
  assign rdata       = rdata_q;
  assign dmem_req    = dmem_req_q;
  assign dmem_we     = dmem_we_q;
  assign dmem_addr   = dmem_addr_q;
  assign dmem_be     = dmem_be_q;
  assign dmem_wdata  = dmem_wdata_q;
  assign dbg_state   = state_q;

endmodule
